// File: rtl/preemph_pkg.sv
// preemph_pkg -- fixed-point scale, pre-emphasis coefficient and the
// quantize/dequantize helpers shared by the pre-emphasis filter.
// Samples and coefficients are signed Q(DATA_WIDTH-QUANT_BITS).QUANT_BITS.
package preemph_pkg;

  // Default sample/coefficient width.
  localparam int DEFAULT_WIDTH = 32;

  // Number of fractional bits in the fixed-point format (1.0 == 0x400).
  localparam int QUANT_BITS = 10;

  // Pre-warped pole ratio for the emphasis corner; PRE_A1 derives from it.
  localparam real W_PP = 39.0;

  // Real-valued constant to fixed point, rounded to nearest.
  function automatic int quantize_f(input real v);
    return int'(v * (2.0 ** QUANT_BITS));
  endfunction

  // Full-precision product back to sample scale (arithmetic shift, floors).
  function automatic longint dequantize(input longint v);
    return v >>> QUANT_BITS;
  endfunction

  // Feed-forward coefficient: exact inverse of the de-emphasis pole.
  localparam int PRE_A1 = quantize_f((W_PP - 1.0) / (W_PP + 1.0));

endpackage

// File: rtl/preemph.sv
// preemph -- first-order FIR pre-emphasis: y[n] = x[n] - DEQUANTIZE(x[n-1]*PRE_A1).
// Two-stage valid/ready pipeline (S1: sample + scaled history product,
// S2: difference into dout). The whole pipe stalls only when S2 holds an
// undelivered sample.
// Build option: define PREEMPH_SAT_EN to clamp the difference to the
// signed DATA_WIDTH range instead of letting it wrap.
module preemph
  import preemph_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dout
);

  // Pipeline and history state.
  logic signed [DATA_WIDTH-1:0] r_hist;
  logic signed [DATA_WIDTH-1:0] r_s1_x;
  logic signed [DATA_WIDTH-1:0] r_s1_prod;
  logic                         r_s1_valid;
  logic        [DATA_WIDTH-1:0] r_dout;
  logic                         r_out_valid;

  // Combinational helpers.
  logic                           w_advance;
  logic                           w_accept;
  logic signed [2*DATA_WIDTH-1:0] w_a1;
  logic signed [2*DATA_WIDTH-1:0] w_hist_ext;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [DATA_WIDTH-1:0]   w_deq;
  logic signed [DATA_WIDTH-1:0]   w_diff;
`ifdef PREEMPH_SAT_EN
  logic signed [DATA_WIDTH:0]     w_diff_wide;
`endif

  // The pipe moves whenever S2 is empty or its sample is being taken.
  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance && !reset;
  assign w_accept  = in_valid && in_ready;

  // History times coefficient at double width, then back to sample scale.
  assign w_a1       = (2*DATA_WIDTH)'(PRE_A1);
  assign w_hist_ext = (2*DATA_WIDTH)'(r_hist);
  assign w_prod     = w_hist_ext * w_a1;
  assign w_deq      = DATA_WIDTH'(dequantize(64'(w_prod)));

  // S2 difference: clamped to the signed range or wrapping, per build option.
  always_comb begin
`ifdef PREEMPH_SAT_EN
    w_diff_wide = {r_s1_x[DATA_WIDTH-1], r_s1_x} - {r_s1_prod[DATA_WIDTH-1], r_s1_prod};
    if (w_diff_wide[DATA_WIDTH] != w_diff_wide[DATA_WIDTH-1]) begin
      if (w_diff_wide[DATA_WIDTH]) begin
        w_diff = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
        w_diff = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
    end else begin
      w_diff = w_diff_wide[DATA_WIDTH-1:0];
    end
`else
    w_diff = r_s1_x - r_s1_prod;
`endif
  end

  // Pipeline advance, history update and synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hist      <= '0;
      r_s1_x      <= '0;
      r_s1_prod   <= '0;
      r_s1_valid  <= 1'b0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_dout <= w_diff;
      end else begin
        r_dout <= r_dout;
      end
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_x    <= din;
        r_s1_prod <= w_deq;
        r_hist    <= din;
      end else begin
        r_s1_x    <= r_s1_x;
        r_s1_prod <= r_s1_prod;
        r_hist    <= r_hist;
      end
    end else begin
      r_out_valid <= r_out_valid;
      r_dout      <= r_dout;
      r_s1_valid  <= r_s1_valid;
      r_s1_x      <= r_s1_x;
      r_s1_prod   <= r_s1_prod;
      r_hist      <= r_hist;
    end
  end

  assign out_valid = r_out_valid;
  assign dout      = r_dout;

endmodule
